// File: rtl/comparator_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// The result encoding is one-hot {g,e,l}.
package comparator_pkg;

  localparam int unsigned CMP_W_MAX = 64;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } cmp_res_t;

  localparam cmp_res_t CMP_GT = 3'b100;
  localparam cmp_res_t CMP_EQ = 3'b010;
  localparam cmp_res_t CMP_LT = 3'b001;

  // Packs final tree (gt, eq) flags into the one-hot result; lt is implied.
  function automatic cmp_res_t cmp_pack(input logic gt, input logic eq);
    cmp_res_t r;
    r.g = gt;
    r.e = eq;
    r.l = ~gt & ~eq;
    return r;
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational unsigned magnitude compare built as a log2(W)-depth tree of
// (gt,eq) merges, with the more significant segment dominating each merge.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output cmp_res_t     res
);

  localparam int unsigned NLVL = $clog2(W);
  localparam int unsigned P    = 1 << NLVL;

  // Zero padding to a power of two gives pad leaves eq=1, gt=0, which are
  // neutral in every merge.
  logic [P-1:0] a_p;
  logic [P-1:0] b_p;

  always_comb begin
    a_p         = '0;
    b_p         = '0;
    a_p[W-1:0]  = a;
    b_p[W-1:0]  = b;
  end

  genvar k, i;
  generate
    for (k = 0; k <= NLVL; k++) begin : g_lvl
      localparam int unsigned N = P >> k;
      logic [N-1:0] gt;
      logic [N-1:0] eq;
      if (k == 0) begin : g_leaf
        assign gt = a_p & ~b_p;
        assign eq = ~(a_p ^ b_p);
      end else begin : g_node
        for (i = 0; i < N; i++) begin : g_m
          assign gt[i] = g_lvl[k-1].gt[2*i+1]
                       | (g_lvl[k-1].eq[2*i+1] & g_lvl[k-1].gt[2*i]);
          assign eq[i] = g_lvl[k-1].eq[2*i+1] & g_lvl[k-1].eq[2*i];
        end
      end
    end
  endgenerate

  always_comb begin
    res = cmp_pack(g_lvl[NLVL].gt[0], g_lvl[NLVL].eq[0]);
  end

endmodule

// File: rtl/comparator.sv
// Registered unsigned comparator: one-hot g/e/l one cycle after in_valid.
// Define COMPARATOR_MINMAX_EN to add registered max_o/min_o outputs.
module comparator
  import comparator_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef COMPARATOR_MINMAX_EN
  output logic [W-1:0] max_o,
  output logic [W-1:0] min_o,
`endif
  output logic         out_valid,
  output logic         g,
  output logic         e,
  output logic         l
);

  generate
    if (W < 1 || W > CMP_W_MAX) begin : g_bad_w
      $error("comparator: W out of range");
    end
  endgenerate

  cmp_res_t cmp_res;

  comparator_core #(.W(W)) u_core (
    .a   (a),
    .b   (b),
    .res (cmp_res)
  );

  logic     valid_d, valid_q;
  cmp_res_t res_d, res_q;

  // Hold muxes select the stored value when idle, so junk on a/b never
  // reaches the result registers.
  always_comb begin
    valid_d = in_valid;
    res_d   = res_q;
    if (in_valid) res_d = cmp_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign out_valid = valid_q;
  assign g         = res_q.g;
  assign e         = res_q.e;
  assign l         = res_q.l;

`ifdef COMPARATOR_MINMAX_EN
  logic [W-1:0] max_d, max_q;
  logic [W-1:0] min_d, min_q;
  logic         a_ge_b;

  always_comb begin
    a_ge_b = cmp_res.g | cmp_res.e;
    max_d  = max_q;
    min_d  = min_q;
    if (in_valid) begin
      max_d = a_ge_b ? a : b;
      min_d = a_ge_b ? b : a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign max_o = max_q;
  assign min_o = min_q;
`endif

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator (W=8 and W=1 instances), hand-computed
// expectations; covers min/max outputs when COMPARATOR_MINMAX_EN is defined.
module tb_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid, g, e, l;

  logic       in_valid1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       out_valid1, g1, e1, l1;

`ifdef COMPARATOR_MINMAX_EN
  logic [7:0] max_o, min_o;
  logic [0:0] max1, min1;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  comparator #(.W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef COMPARATOR_MINMAX_EN
    .max_o     (max_o),
    .min_o     (min_o),
`endif
    .out_valid (out_valid),
    .g         (g),
    .e         (e),
    .l         (l)
  );

  comparator #(.W(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
`ifdef COMPARATOR_MINMAX_EN
    .max_o     (max1),
    .min_o     (min1),
`endif
    .out_valid (out_valid1),
    .g         (g1),
    .e         (e1),
    .l         (l1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    in_valid = v;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] r;
    logic [7:0] mx;
    logic [7:0] mn;
  } vec_t;

  vec_t vecs [11] = '{
    '{8'd5,   8'd10,  3'b001, 8'd10,  8'd5},
    '{8'd5,   8'd5,   3'b010, 8'd5,   8'd5},
    '{8'd5,   8'd2,   3'b100, 8'd5,   8'd2},
    '{8'd3,   8'd3,   3'b010, 8'd3,   8'd3},
    '{8'd1,   8'd6,   3'b001, 8'd6,   8'd1},
    '{8'd255, 8'd0,   3'b100, 8'd255, 8'd0},
    '{8'd0,   8'd255, 3'b001, 8'd255, 8'd0},
    '{8'd0,   8'd0,   3'b010, 8'd0,   8'd0},
    '{8'd128, 8'd127, 3'b100, 8'd128, 8'd127},
    '{8'd127, 8'd128, 3'b001, 8'd128, 8'd127},
    '{8'd7,   8'd7,   3'b010, 8'd7,   8'd7}
  };

  initial begin
    // Reset held with a valid input present.
    in_valid = 1'b1;
    a        = 8'd5;
    b        = 8'd10;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_gel", {g, e, l}, 3'b000);
    check("rst_valid_w1", out_valid1, 0);
`ifdef COMPARATOR_MINMAX_EN
    check("rst_max", max_o, 0);
    check("rst_min", min_o, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_gel", {g, e, l}, 3'b001);

    // Back-to-back directed and extreme vectors.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_gel", i), {g, e, l}, vecs[i].r);
      check($sformatf("vec%0d_onehot", i), $countones({g, e, l}), 1);
`ifdef COMPARATOR_MINMAX_EN
      check($sformatf("vec%0d_max", i), max_o, vecs[i].mx);
      check($sformatf("vec%0d_min", i), min_o, vecs[i].mn);
`endif
    end

    // Idle gaps hold the last result.
    step(1'b1, 8'd9, 8'd4);
    check("gap_first_gel", {g, e, l}, 3'b100);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom));
      check($sformatf("gap%0d_valid", i), out_valid, 0);
      check($sformatf("gap%0d_gel", i), {g, e, l}, 3'b100);
`ifdef COMPARATOR_MINMAX_EN
      check($sformatf("gap%0d_max", i), max_o, 8'd9);
      check($sformatf("gap%0d_min", i), min_o, 8'd4);
`endif
    end

    // Asynchronous reset between edges.
    step(1'b1, 8'd2, 8'd2);
    check("pre_async_valid", out_valid, 1);
    check("pre_async_gel", {g, e, l}, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_gel", {g, e, l}, 3'b000);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = 8'd200;
    b        = 8'd100;
    @(posedge clk);
    #1;
    check("resume_valid", out_valid, 1);
    check("resume_gel", {g, e, l}, 3'b100);
    step(1'b0, 8'd0, 8'd0);

    // W=1 exhaustive sweep.
    for (int i = 0; i < 4; i++) begin
      logic       ea, eb;
      logic [2:0] er;
      ea = i[1];
      eb = i[0];
      er = (ea > eb) ? 3'b100 : (ea == eb) ? 3'b010 : 3'b001;
      @(negedge clk);
      in_valid1 = 1'b1;
      a1        = ea;
      b1        = eb;
      @(posedge clk);
      #1;
      check($sformatf("w1_%0d_valid", i), out_valid1, 1);
      check($sformatf("w1_%0d_gel", i), {g1, e1, l1}, er);
`ifdef COMPARATOR_MINMAX_EN
      check($sformatf("w1_%0d_max", i), max1, ea | eb);
      check($sformatf("w1_%0d_min", i), min1, ea & eb);
`endif
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    check("w1_idle_valid", out_valid1, 0);
    check("w1_idle_hold", {g1, e1, l1}, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
